// File: rtl/cpu_data_receiver_s_axi.sv
// cpu_data_receiver_s_axi
// AXI4-Lite slave that hands fabric words to the CPU. Fabric pushes 32-bit
// words over valid/ready into a FIFO; the CPU pops them through the DATA
// register and observes STATUS / RXCNT. CTRL flushes the FIFO, clears the
// underflow sticky bit and clears the word counter.
module cpu_data_receiver_s_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   in_data,
  input  logic                            in_valid,
  output logic                            in_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_RXCNT  = 2'd3;

  // write channel state
  logic        r_aw_held, r_w_held, r_bvalid, r_wstrb0;
  logic [1:0]  r_awsel;
  logic [2:0]  r_wctl;
  // read channel state
  logic        r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  // FIFO and counters
  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_rxcnt;
  logic          r_underflow;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_ctl_wr;
  logic w_flush, w_clr_uf, w_clr_cnt;
  logic w_empty, w_full, w_push, w_pop, w_uf_set;
  logic [1:0]  w_arsel;
  logic [31:0] w_status, w_rd_mux;
  logic        w_unused;

  // Readies come from registered state only; held low while in reset.
  assign S_AXI_AWREADY = !ARESET && !r_aw_held && !r_bvalid;
  assign S_AXI_WREADY  = !ARESET && !r_w_held  && !r_bvalid;
  assign S_AXI_ARREADY = !ARESET && !r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_arsel  = S_AXI_ARADDR[3:2];

  // Commit: both halves latched and no response pending.
  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;
  assign w_ctl_wr  = w_commit && (r_awsel == SEL_CTRL) && r_wstrb0;
  assign w_flush   = w_ctl_wr && r_wctl[0];
  assign w_clr_uf  = w_ctl_wr && r_wctl[1];
  assign w_clr_cnt = w_ctl_wr && r_wctl[2];

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  // Blocking pushes during a flush keeps a word from being dropped by it.
  assign in_ready = !w_full && !w_flush;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = w_ar_hs && (w_arsel == SEL_DATA) && !w_empty;
  assign w_uf_set = w_ar_hs && (w_arsel == SEL_DATA) && w_empty;

  assign w_status = {16'h0, 8'(r_count), 5'h0, r_underflow, w_full, w_empty};

  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[1:0], S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1],
                      S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:3]};

  // AW/W latch independently; commit moves them into a B response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awsel   <= 2'd0;
      r_wctl    <= 3'd0;
      r_wstrb0  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awsel   <= S_AXI_AWADDR[3:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wctl   <= S_AXI_WDATA[2:0];
          r_wstrb0 <= S_AXI_WSTRB[0];
        end
        if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
      end
    end
  end

  // Read data selection, sampled at the AR handshake.
  always_comb begin
    w_rd_mux = 32'h0;
    case (w_arsel)
      SEL_DATA:   w_rd_mux = w_empty ? 32'h0 : r_mem[r_rd_ptr];
      SEL_STATUS: w_rd_mux = w_status;
      SEL_CTRL:   w_rd_mux = 32'h0;
      SEL_RXCNT:  w_rd_mux = r_rxcnt;
      default:    w_rd_mux = 32'h0;
    endcase
  end

  // R response registered one cycle after AR, held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_mux;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset, pointers/count define validity.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; a flush wins after the pop has read the head.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Word counter and underflow sticky. A push in the clear cycle still counts;
  // a new underflow beats a clear in the same cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rxcnt     <= 32'h0;
      r_underflow <= 1'b0;
    end else begin
      if (w_clr_cnt)   r_rxcnt <= w_push ? 32'h1 : 32'h0;
      else if (w_push) r_rxcnt <= r_rxcnt + 32'h1;
      if (w_uf_set)      r_underflow <= 1'b1;
      else if (w_clr_uf) r_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_data_receiver_s_axi.sv
// Bench for cpu_data_receiver_s_axi: table of register accesses plus
// hand-written sequences for fill, underflow, flush, counter wrap and reset.
module tb_cpu_data_receiver_s_axi;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_ARVALID = 0;
  logic        S_AXI_BREADY = 1, S_AXI_RREADY = 1;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic [31:0] in_data = '0;
  logic        in_valid = 0, in_ready;

  cpu_data_receiver_s_axi dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tv[10];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    ARESET = 1'b1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0; in_valid = 0;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    exp_q.delete(); name_q.delete();
    @(negedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    #1;
  endtask

  task automatic push_words(int n, logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_data = base + 32'(i);
      in_valid = 1'b1;
      while (!in_ready && t < 50) begin @(negedge ACLK); t++; end
      if (!in_ready) timeout("push");
      @(negedge ACLK);
    end
    in_valid = 1'b0;
  endtask

  task automatic axi_write(logic [3:0] addr, logic [31:0] data, logic [3:0] strb, bit wait_b);
    int t = 0;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1;
    S_AXI_WDATA = data;  S_AXI_WSTRB = strb; S_AXI_WVALID = 1;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && t < 50) begin
      bit aw_hs, w_hs;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK); t++;
      if (aw_hs) S_AXI_AWVALID = 0;
      if (w_hs)  S_AXI_WVALID = 0;
    end
    if (S_AXI_AWVALID || S_AXI_WVALID) begin
      timeout("aw_w_handshake");
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    end
    if (wait_b) begin
      t = 0;
      while (!S_AXI_BVALID && t < 50) begin @(negedge ACLK); t++; end
      if (!S_AXI_BVALID) timeout("bvalid");
      else begin
        check("bresp", 32'(S_AXI_BRESP), 32'h0);
        @(negedge ACLK);
      end
    end
  endtask

  // Expected value is queued when AR is driven and popped when R arrives.
  task automatic axi_read(logic [3:0] addr, logic [31:0] exp, string nm);
    int t = 0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
    while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    t = 0;
    while (!S_AXI_RVALID && t < 50) begin @(negedge ACLK); t++; end
    if (!S_AXI_RVALID) begin
      timeout({nm, "_rvalid"});
      void'(exp_q.pop_front()); void'(name_q.pop_front());
    end else begin
      string n2;
      logic [31:0] e;
      n2 = name_q.pop_front();
      e  = exp_q.pop_front();
      check(n2, S_AXI_RDATA, e);
      check({n2, "_rresp"}, 32'(S_AXI_RRESP), 32'h0);
      @(negedge ACLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes, lows, bs;
    // reset state
    @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 0);
    check("rst_wready",  32'(S_AXI_WREADY), 0);
    check("rst_arready", 32'(S_AXI_ARREADY), 0);
    check("rst_bvalid",  32'(S_AXI_BVALID), 0);
    check("rst_rvalid",  32'(S_AXI_RVALID), 0);
    check("rst_rdata",   S_AXI_RDATA, 0);
    ARESET = 1'b0; #1;
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_awready",  32'(S_AXI_AWREADY), 1);

    // 1: ordered drain through the register table
    tv[0] = '{0, 4'h4, 32'h0, 32'h0000_0400, "t1_status4"};
    tv[1] = '{1, 4'h0, 32'hDEAD, 32'h0, "t1_wr_data_ignored"};
    tv[2] = '{0, 4'h0, 32'h0, 32'h0000_00A0, "t1_data0"};
    tv[3] = '{0, 4'h0, 32'h0, 32'h0000_00A1, "t1_data1"};
    tv[4] = '{0, 4'h4, 32'h0, 32'h0000_0200, "t1_status2"};
    tv[5] = '{0, 4'h0, 32'h0, 32'h0000_00A2, "t1_data2"};
    tv[6] = '{0, 4'h0, 32'h0, 32'h0000_00A3, "t1_data3"};
    tv[7] = '{0, 4'h4, 32'h0, 32'h0000_0001, "t1_status_empty"};
    tv[8] = '{0, 4'hC, 32'h0, 32'h0000_0004, "t1_rxcnt"};
    tv[9] = '{0, 4'h8, 32'h0, 32'h0000_0000, "t1_ctrl_reads0"};
    @(negedge ACLK);
    push_words(4, 32'hA0);
    for (int i = 0; i < 10; i++) begin
      if (tv[i].wr) axi_write(tv[i].addr, tv[i].wdata, 4'hF, 1);
      else          axi_read(tv[i].addr, tv[i].exp, tv[i].nm);
    end

    // 2: fill to depth, then one pop frees exactly one slot
    do_reset();
    pushes = 0;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h100 + 32'(i);
      if (in_ready) pushes++;
      @(negedge ACLK);
    end
    in_valid = 0;
    check("t2_pushes", 32'(pushes), 16);
    check("t2_in_ready_full", 32'(in_ready), 0);
    axi_read(4'h4, 32'h0000_1002, "t2_status_full");
    axi_read(4'h0, 32'h0000_0100, "t2_pop_head");
    check("t2_in_ready_after_pop", 32'(in_ready), 1);
    pushes = 0;
    in_valid = 1; in_data = 32'h200;
    for (int i = 0; i < 3; i++) begin
      if (in_ready) pushes++;
      @(negedge ACLK);
    end
    in_valid = 0;
    check("t2_one_more_push", 32'(pushes), 1);
    axi_read(4'hC, 32'd17, "t2_rxcnt");

    // 3: underflow sticky, clear ignored without WSTRB[0]
    do_reset();
    axi_read(4'h0, 32'h0, "t3_empty_data");
    axi_read(4'h4, 32'h0000_0005, "t3_status_uf");
    axi_write(4'h8, 32'h2, 4'h0, 1);
    axi_read(4'h4, 32'h0000_0005, "t3_uf_kept_nostrb");
    axi_write(4'h8, 32'h2, 4'h1, 1);
    axi_read(4'h4, 32'h0000_0001, "t3_uf_cleared");

    // 4: flush with W one cycle ahead of AW
    do_reset();
    push_words(5, 32'h300);
    lows = 0; bs = 0;
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'h1; S_AXI_WVALID = 1;
    check("t4_wready", 32'(S_AXI_WREADY), 1);
    @(negedge ACLK);
    S_AXI_WVALID = 0; S_AXI_AWVALID = 1;
    for (int c = 0; c < 8; c++) begin
      bit aw_hs;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      if (!in_ready) lows++;
      if (S_AXI_BVALID) bs++;
      @(negedge ACLK);
      if (aw_hs) S_AXI_AWVALID = 0;
    end
    S_AXI_AWVALID = 0;
    check("t4_in_ready_low_cycles", 32'(lows), 1);
    check("t4_single_b", 32'(bs), 1);
    axi_read(4'h4, 32'h0000_0001, "t4_status_flushed");
    axi_read(4'hC, 32'd5, "t4_rxcnt_kept");

    // 5: counter clear and wrap
    do_reset();
    push_words(7, 32'h400);
    axi_read(4'hC, 32'd7, "t5_rxcnt7");
    axi_write(4'h8, 32'h4, 4'h1, 1);
    axi_read(4'hC, 32'd0, "t5_rxcnt_cleared");
    axi_read(4'h4, 32'h0000_0700, "t5_fifo_kept");
    force dut.r_rxcnt = 32'hFFFF_FFFF;
    @(negedge ACLK);
    release dut.r_rxcnt;
    axi_read(4'hC, 32'hFFFF_FFFF, "t5_preload");
    push_words(1, 32'h500);
    axi_read(4'hC, 32'd0, "t5_wrap");

    // 6: reset with B and R responses pending
    do_reset();
    push_words(3, 32'h600);
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    axi_write(4'h8, 32'h0, 4'h1, 0);
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    @(negedge ACLK);
    check("t6_bvalid_pending", 32'(S_AXI_BVALID), 1);
    check("t6_rvalid_pending", 32'(S_AXI_RVALID), 1);
    ARESET = 1; #1;
    check("t6_bvalid_dropped", 32'(S_AXI_BVALID), 0);
    check("t6_rvalid_dropped", 32'(S_AXI_RVALID), 0);
    @(negedge ACLK);
    ARESET = 0; S_AXI_BREADY = 1; S_AXI_RREADY = 1; #1;
    check("t6_in_ready", 32'(in_ready), 1);
    axi_read(4'h4, 32'h0000_0001, "t6_status_empty");
    axi_read(4'hC, 32'd0, "t6_rxcnt0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
